// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. buffered long-latency writebacks,
// fixed priority to the pipeline with a starvation guard that forces the FIFO head.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [ADDR_WIDTH-1:0] p_waddr,
  input  logic [DATA_WIDTH-1:0] p_wdata,
  input  logic                  l_valid,
  output logic                  l_ready,
  input  logic [ADDR_WIDTH-1:0] l_waddr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  l_pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_reg, pending_reg;
  logic [SW-1:0]         starve_reg, starve_next;
  logic                  push, pop, grant_p, grant;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  wen_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  // pending_reg mirrors count_reg != 0, so it doubles as the FIFO head-valid flag.
  always_comb begin
    state_next  = NORMAL;
    starve_next = starve_reg;
    grant_p     = 1'b0;
    pop         = 1'b0;
    if (state_reg == FORCE) pop = pending_reg;
    else if (p_valid)       grant_p = 1'b1;
    else                    pop = pending_reg;

    if (pop || !pending_reg) begin
      starve_next = '0;
    end else if (grant_p) begin
      if (starve_reg == SW'(STARVE_LIMIT - 1)) begin
        starve_next = '0;
        state_next  = FORCE;
      end else begin
        starve_next = starve_reg + 1'b1;
      end
    end

    grant  = grant_p || pop;
    g_addr = pop ? addr_mem[rd_ptr_reg] : p_waddr;
    g_data = pop ? data_mem[rd_ptr_reg] : p_wdata;
  end

  assign push       = l_valid && !full_reg;
  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= l_waddr;
      data_mem[wr_ptr_reg] <= l_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= NORMAL;
      starve_reg  <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      full_reg    <= 1'b0;
      pending_reg <= 1'b0;
      wen_reg     <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      starve_reg  <= starve_next;
      count_reg   <= count_next;
      full_reg    <= (count_next == CW'(FIFO_DEPTH));
      pending_reg <= (count_next != '0);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Writes to r0 still consume their grant but never reach the register file.
      wen_reg <= grant && (g_addr != '0);
      if (grant) begin
        waddr_reg <= g_addr;
        wdata_reg <= g_data;
      end
    end
  end

  assign p_ready   = grant_p;
  assign l_ready   = !full_reg;
  assign l_pending = pending_reg;
  assign rf_wen    = wen_reg;
  assign rf_waddr  = waddr_reg;
  assign rf_wdata  = wdata_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_rf_wb_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2, LIMIT = 4;

  logic clk = 1'b0, resetn = 1'b0;
  logic p_valid = 1'b0, l_valid = 1'b0;
  logic [AW-1:0] p_waddr = '0, l_waddr = '0;
  logic [DW-1:0] p_wdata = '0, l_wdata = '0;
  logic p_ready, l_ready, rf_wen, l_pending;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .p_valid(p_valid), .p_ready(p_ready), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .l_pending(l_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Reference model: waiting long-latency writes, how many cycles the head has lost
  // in a row, and whether the next cycle belongs to the FIFO unconditionally.
  logic [AW+DW-1:0] q[$];
  int   lost = 0;
  bit   force_m = 0;
  bit   e_wen = 0, e_rst = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  bit   last_pready = 0;
  int   n_pgrants = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                            input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                            input bit rn);
    bit push, gp, gl, waiting, force_new;
    logic [AW+DW-1:0] head;
    e_rst = !rn;
    if (!rn) begin
      q.delete(); lost = 0; force_m = 0;
      e_wen = 0; e_addr = '0; e_data = '0;
      return;
    end
    waiting = (q.size() != 0);
    push = lv && (q.size() < DEPTH);
    gp = 0; gl = 0;
    if (force_m)  gl = waiting;
    else if (pv)  gp = 1;
    else          gl = waiting;
    e_wen = 0;
    if (gp) begin
      e_wen = (pa != 0); e_addr = pa; e_data = pd;
      n_pgrants++;
    end
    if (gl) begin
      head = q.pop_front();
      e_addr = head[AW+DW-1:DW]; e_data = head[DW-1:0];
      e_wen = (e_addr != 0);
    end
    force_new = 0;
    if (waiting && gp) begin
      lost++;
      if (lost == LIMIT) begin force_new = 1; lost = 0; end
    end else begin
      lost = 0;
    end
    force_m = force_new;
    if (push) q.push_back({la, ld});
  endtask

  // One clock: drive inputs, check the combinational grant, advance, check registered outputs.
  task automatic cycle(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit rn);
    p_valid = pv; p_waddr = pa; p_wdata = pd;
    l_valid = lv; l_waddr = la; l_wdata = ld;
    resetn  = rn;
    #1;
    last_pready = pv && !force_m;
    if (rn) check("p_ready", 64'(p_ready), 64'(last_pready));
    model_step(pv, pa, pd, lv, la, ld, rn);
    @(posedge clk);
    #1;
    check("rf_wen", 64'(rf_wen), 64'(e_wen));
    if (e_wen || e_rst) begin
      check("rf_waddr", 64'(rf_waddr), 64'(e_addr));
      check("rf_wdata", 64'(rf_wdata), 64'(e_data));
    end
    check("l_ready", 64'(l_ready), 64'(q.size() < DEPTH));
    check("l_pending", 64'(l_pending), 64'(q.size() != 0));
    if (rf_wen) $display("write r%0d = %08h at %0t", rf_waddr, rf_wdata, $time);
  endtask

  initial begin
    bit pv, lv, rn;
    logic [AW-1:0] pa, la;
    logic [DW-1:0] pd, ld;
    int start;
    @(posedge clk); #1;

    // Reset held two cycles with a pipeline request present
    cycle(1, 5'd3, 32'h1, 0, '0, '0, 0);
    cycle(1, 5'd3, 32'h1, 0, '0, '0, 0);

    // Pipeline only
    cycle(1, 5'd5, 32'h1234, 0, '0, '0, 1);
    check("pipe_waddr", 64'(rf_waddr), 64'd5);
    check("pipe_wdata", 64'(rf_wdata), 64'h1234);

    // Long-latency only: two pushes, drained in order
    cycle(0, '0, '0, 1, 5'd9, 32'hAA, 1);
    cycle(0, '0, '0, 1, 5'd10, 32'hBB, 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, '0, '0, 1);

    // Full/backpressure and starvation: pipeline busy, FIFO forced every LIMIT+1 cycles
    start = n_pgrants;
    cycle(1, 5'd1, 32'h100, 1, 5'd9, 32'hAA, 1);
    cycle(1, 5'd1, 32'h101, 1, 5'd10, 32'hBB, 1);
    check("full_after_two", 64'(l_ready), 64'd0);
    cycle(1, 5'd1, 32'h102, 1, 5'd11, 32'hCC, 1);
    cycle(1, 5'd1, 32'h103, 0, '0, '0, 1);
    cycle(1, 5'd1, 32'h104, 0, '0, '0, 1);
    check("pgrants_before_force", 64'(n_pgrants - start), 64'd5);
    cycle(1, 5'd1, 32'h104, 0, '0, '0, 1);
    check("forced_addr", 64'(rf_waddr), 64'd9);
    check("forced_data", 64'(rf_wdata), 64'hAA);
    for (int i = 0; i < 8; i++) cycle(1, 5'd2, 32'h200 + i, 0, '0, '0, 1);
    check("fifo_drained", 64'(l_pending), 64'd0);

    // Address 0 grant consumes the handshake without writing
    cycle(1, 5'd0, 32'hDEAD, 0, '0, '0, 1);
    check("r0_no_write", 64'(rf_wen), 64'd0);

    // Reset mid-flight with two entries queued
    cycle(1, 5'd4, 32'h44, 1, 5'd12, 32'h12, 1);
    cycle(1, 5'd4, 32'h45, 1, 5'd13, 32'h13, 1);
    cycle(1, 5'd4, 32'h46, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, '0, '0, 1);

    // Random traffic; a refused pipeline or long-latency request is held stable
    pv = 0; lv = 0; pa = '0; la = '0; pd = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(pv && !last_pready)) begin
        pv = ($urandom_range(0, 9) < 6);
        pa = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        pd = $urandom;
      end
      if (!(lv && q.size() >= DEPTH)) begin
        lv = ($urandom_range(0, 1) == 1);
        la = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        ld = $urandom;
      end
      rn = ($urandom_range(0, 49) != 0);
      cycle(pv, pa, pd, lv, la, ld, rn);
      if (!rn) begin pv = 0; lv = 0; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
